m6502_step_ctl: RTL and testbench
=================================

// Module: m6502_step_ctl
// PURPOSE
//  Instruction-count / breakpoint run controller upstream of the m6502_db RDY OR-gate.
//  After a START press it lets the 6502 run exactly STEPS instructions, or until a SYNC fetch hits BP_ADDR.
//  It then parks the CPU on the next opcode fetch by dropping RDY_REQ.
//  RDY_REQ is the 4th term of the RDY OR; CUR_RDY is the final RDY fed back in.
// PARAMETERS
//  CW  8   step-counter width (max STEPS = 2**CW-1)
//  AW  16  address width compared for breakpoint
// PORTS
//  PHI2      in   1   clock; all state updates on PHI2 rising edge
//  RESET     in   1   synchronous, active-high reset
//  SYNC      in   1   6502 SYNC, active high (opcode fetch cycle)
//  CUR_RDY   in   1   RDY currently presented to the CPU (cycle completes when 1)
//  ADDR      in   AW  CPU address bus, valid at PHI2 rise
//  START_N   in   1   debounced START button, active low, asynchronous
//  ABORT_N   in   1   debounced ABORT button, active low, asynchronous
//  STEPS     in   CW  instruction count (DIP switches), sampled on START
//  BP_EN     in   1   breakpoint enable (static switch)
//  BP_ADDR   in   AW  breakpoint address (static switches)
//  RDY_REQ   out  1   run request to RDY OR-gate
//  BUSY      out  1   state==RUN
//  DONE      out  1   halted by count or breakpoint; held until next START/RESET
//  BP_HIT    out  1   DONE was caused by breakpoint (not count)
//  REMAIN    out  CW  remaining instruction count
// BEHAVIOUR
//  Reset: state=IDLE; RDY_REQ=0 BUSY=0 DONE=0 BP_HIT=0 REMAIN=0; sync flops cleared.
//  START_N/ABORT_N each pass through a 2-FF synchroniser and a falling-edge detector.
//  Result: one-cycle start_p/abort_p pulses, 3 PHI2 edges after the press.
//  fetch  = SYNC & CUR_RDY (an opcode fetch that completes this cycle).
//  bp_hit = BP_EN & SYNC & (ADDR==BP_ADDR).
//  States: IDLE, RUN, DONE (2-bit encoding).
//   IDLE: RDY_REQ=0. start_p & STEPS!=0 -> RUN, REMAIN<=STEPS.
//         start_p & STEPS==0 -> DONE, BP_HIT=0 (zero-step run: immediate done).
//   RUN: each fetch with REMAIN!=0 and !bp_hit -> REMAIN<=REMAIN-1.
//        SYNC & (REMAIN==0 | bp_hit) -> DONE; BP_HIT<=bp_hit; REMAIN unchanged.
//        abort_p -> IDLE, REMAIN<=0.
//   DONE: RDY_REQ=0, DONE=1. start_p re-arms exactly as from IDLE and clears BP_HIT.
//         abort_p -> IDLE.
//  RDY_REQ = (state==RUN) & !(SYNC & (REMAIN==0 | bp_hit)).
//   The combinational drop parks the CPU in the SYNC cycle of instruction STEPS+1, or of the bp instruction.
//   Only this term may be combinational; all other outputs are registered.
//  Counting: the 1st fetch after START counts as instruction 1 only if REMAIN!=0; REMAIN never wraps below 0.
//  The bp check precedes counting on the same fetch: a bp at the 1st fetch halts with 0 instructions run.
//  Write cycles and SYNC with CUR_RDY=0 (stalled fetch) never decrement.
//  Simultaneous start_p & abort_p: abort wins.
//  RESET mid-RUN: immediate IDLE, RDY_REQ low on the same edge; no partial state survives.
//  STEPS/BP_ADDR changes while in RUN are ignored for count; BP_ADDR is live (static by usage).
// STRUCTURE
//  Shared include m6502_db_defs.vh: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; default CW/AW.
//  One sub-module: sync_edge (2-FF synchroniser + falling-edge pulse); instantiated twice (START, ABORT).
//  Top: FSM, down-counter, AW-bit comparator, output decode.
// TESTING
//  1. RESET high 2 cycles mid-RUN -> RDY_REQ=0, BUSY=0, DONE=0, REMAIN=0 on the next edge.
//  2. STEPS=3, START; SYNC every 4th cycle, CUR_RDY=1 -> 3 fetches pass; 4th SYNC sees RDY_REQ=0; DONE=1, BP_HIT=0.
//  3. STEPS=5, BP_EN=1, BP_ADDR=16'hF00D; 2nd fetch ADDR=F00D -> RDY_REQ=0 that cycle; DONE=1, BP_HIT=1, REMAIN=4.
//  4. STEPS=2; one SYNC with CUR_RDY=0 held 3 cycles -> REMAIN stays 2 until CUR_RDY=1.
//  5. STEPS=0, START -> straight to DONE, RDY_REQ never high; START again from DONE with STEPS=1 -> exactly 1 fetch.
//  6. START and ABORT pressed together while IDLE -> stays IDLE; ABORT during RUN (REMAIN=7) -> IDLE, REMAIN=0.

Source files
------------

// File: rtl/m6502_step_ctl_pkg.sv
// Shared definitions for the 6502 instruction-step / breakpoint run controller.
package m6502_step_ctl_pkg;

  localparam int unsigned CW_DEF = 8;
  localparam int unsigned AW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/m6502_step_ctl_sync_edge.sv
// Two-flop synchroniser for an active-low button followed by a falling-edge pulse.
module sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_n,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_last;

  // Clearing to 0 looks like a held button, so release after reset never pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_last <= 1'b0;
    end else begin
      r_meta <= i_btn_n;
      r_sync <= r_meta;
      r_last <= r_sync;
    end
  end

  assign o_fall = r_last & ~r_sync;

endmodule

// File: rtl/m6502_step_ctl.sv
// Run controller: lets the 6502 execute STEPS instructions or run to a breakpoint, then parks it.
module m6502_step_ctl
  import m6502_step_ctl_pkg::*;
#(
  parameter int unsigned CW = CW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          PHI2,
  input  logic          RESET,
  input  logic          SYNC,
  input  logic          CUR_RDY,
  input  logic [AW-1:0] ADDR,
  input  logic          START_N,
  input  logic          ABORT_N,
  input  logic [CW-1:0] STEPS,
  input  logic          BP_EN,
  input  logic [AW-1:0] BP_ADDR,
  output logic          RDY_REQ,
  output logic          BUSY,
  output logic          DONE,
  output logic          BP_HIT,
  output logic [CW-1:0] REMAIN
);

  localparam logic [CW-1:0] ONE = CW'(1);

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_remain, w_remain_nx;
  logic          r_bp_hit, w_bp_hit_nx;
  logic          w_start_p;
  logic          w_abort_p;
  logic          w_fetch;
  logic          w_bp;
  logic          w_park;

  sync_edge u_start (
    .i_clk   (PHI2),
    .i_rst   (RESET),
    .i_btn_n (START_N),
    .o_fall  (w_start_p)
  );

  sync_edge u_abort (
    .i_clk   (PHI2),
    .i_rst   (RESET),
    .i_btn_n (ABORT_N),
    .o_fall  (w_abort_p)
  );

  assign w_fetch = SYNC & CUR_RDY;
  assign w_bp    = BP_EN & SYNC & (ADDR == BP_ADDR);
  assign w_park  = SYNC & ((r_remain == '0) | w_bp);

  always_ff @(posedge PHI2) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_remain <= '0;
      r_bp_hit <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_remain <= w_remain_nx;
      r_bp_hit <= w_bp_hit_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_remain_nx = r_remain;
    w_bp_hit_nx = r_bp_hit;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_abort_p) begin
          w_state_nx = ST_IDLE;
        end else if (w_start_p) begin
          w_remain_nx = STEPS;
          w_bp_hit_nx = 1'b0;
          w_state_nx  = (STEPS != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        // Park check precedes counting, so a breakpoint fetch is never counted.
        if (w_abort_p) begin
          w_state_nx  = ST_IDLE;
          w_remain_nx = '0;
        end else if (w_park) begin
          w_state_nx  = ST_DONE;
          w_bp_hit_nx = w_bp;
        end else if (w_fetch && (r_remain != '0)) begin
          w_remain_nx = r_remain - ONE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  assign RDY_REQ = (r_state == ST_RUN) & ~w_park;
  assign BUSY    = (r_state == ST_RUN);
  assign DONE    = (r_state == ST_DONE);
  assign BP_HIT  = r_bp_hit;
  assign REMAIN  = r_remain;

endmodule

// File: tb/tb_m6502_step_ctl.sv
// Scenario bench for m6502_step_ctl: expected per-cycle outputs are queued and checked cycle by cycle.
module tb_m6502_step_ctl;

  logic        PHI2;
  logic        RESET;
  logic        SYNC;
  logic        CUR_RDY;
  logic [15:0] ADDR;
  logic        START_N;
  logic        ABORT_N;
  logic [7:0]  STEPS;
  logic        BP_EN;
  logic [15:0] BP_ADDR;
  logic        RDY_REQ;
  logic        BUSY;
  logic        DONE;
  logic        BP_HIT;
  logic [7:0]  REMAIN;

  typedef struct {
    logic       rdy;
    logic       busy;
    logic       done;
    logic [7:0] rem;
  } exp_t;

  exp_t  exp_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  string cur_tag = "init";

  m6502_step_ctl #(.CW(8), .AW(16)) dut (
    .PHI2    (PHI2),
    .RESET   (RESET),
    .SYNC    (SYNC),
    .CUR_RDY (CUR_RDY),
    .ADDR    (ADDR),
    .START_N (START_N),
    .ABORT_N (ABORT_N),
    .STEPS   (STEPS),
    .BP_EN   (BP_EN),
    .BP_ADDR (BP_ADDR),
    .RDY_REQ (RDY_REQ),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .BP_HIT  (BP_HIT),
    .REMAIN  (REMAIN)
  );

  initial PHI2 = 1'b0;
  always #5 PHI2 = ~PHI2;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t mk(input logic rdy, input logic busy, input logic done,
                              input logic [7:0] rem);
    exp_t e;
    e.rdy  = rdy;
    e.busy = busy;
    e.done = done;
    e.rem  = rem;
    return e;
  endfunction

  // Entered just after a falling edge: RDY_REQ is checked before the rising edge,
  // registered outputs at the following falling edge.
  task automatic tick(input logic sync, input logic cur_rdy, input logic [15:0] addr);
    exp_t e;
    SYNC    = sync;
    CUR_RDY = cur_rdy;
    ADDR    = addr;
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s scoreboard: got empty queue, required an entry", cur_tag);
      @(negedge PHI2);
    end else begin
      e = exp_q.pop_front();
      n_vec++;
      if (RDY_REQ !== e.rdy) begin
        n_bad++;
        $display("FAIL %s rdy_req: got %b required %b", cur_tag, RDY_REQ, e.rdy);
      end
      @(negedge PHI2);
      n_vec++;
      if (BUSY !== e.busy) begin
        n_bad++;
        $display("FAIL %s busy: got %b required %b", cur_tag, BUSY, e.busy);
      end
      n_vec++;
      if (DONE !== e.done) begin
        n_bad++;
        $display("FAIL %s done: got %b required %b", cur_tag, DONE, e.done);
      end
      n_vec++;
      if (REMAIN !== e.rem) begin
        n_bad++;
        $display("FAIL %s remain: got %0d required %0d", cur_tag, REMAIN, e.rem);
      end
    end
  endtask

  // Button press: pulse acts on the 3rd rising edge; two settle cycles follow release.
  task automatic press(input logic s, input logic a, input logic [7:0] steps,
                       input exp_t pre, input exp_t post);
    exp_t after;
    STEPS   = steps;
    START_N = ~s;
    ABORT_N = ~a;
    exp_q.push_back(pre);
    tick(1'b0, 1'b1, 16'h0000);
    exp_q.push_back(pre);
    tick(1'b0, 1'b1, 16'h0000);
    exp_q.push_back(post);
    tick(1'b0, 1'b1, 16'h0000);
    START_N = 1'b1;
    ABORT_N = 1'b1;
    after     = post;
    after.rdy = post.busy;
    repeat (2) begin
      exp_q.push_back(after);
      tick(1'b0, 1'b1, 16'h0000);
    end
  endtask

  task automatic check_bp(input logic want);
    n_vec++;
    if (BP_HIT !== want) begin
      n_bad++;
      $display("FAIL %s bp_hit: got %b required %b", cur_tag, BP_HIT, want);
    end
  endtask

  task automatic test_reset;
    cur_tag = "reset";
    RESET = 1'b1; START_N = 1'b1; ABORT_N = 1'b1; SYNC = 1'b0; CUR_RDY = 1'b1;
    ADDR = '0; STEPS = '0; BP_EN = 1'b0; BP_ADDR = '0;
    repeat (2) @(negedge PHI2);
    n_vec++; if (RDY_REQ !== 1'b0) begin n_bad++; $display("FAIL reset rdy_req: got %b required 0", RDY_REQ); end
    n_vec++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b required 0", BUSY); end
    n_vec++; if (DONE !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b required 0", DONE); end
    check_bp(1'b0);
    n_vec++; if (REMAIN !== 8'd0) begin n_bad++; $display("FAIL reset remain: got %0d required 0", REMAIN); end
    RESET = 1'b0;
    repeat (4) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0));
      tick(1'b0, 1'b1, 16'h0000);
    end
  endtask

  task automatic test_count;
    cur_tag = "count3";
    BP_EN = 1'b0;
    press(1'b1, 1'b0, 8'd3, mk(1'b0, 1'b0, 1'b0, 8'd0), mk(1'b0, 1'b1, 1'b0, 8'd3));
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 8'(2 - f)));
      tick(1'b1, 1'b1, 16'h1000 + 16'(f));
      repeat (3) begin
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 8'(2 - f)));
        tick(1'b0, 1'b1, 16'h2000);
      end
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 8'd0));
    tick(1'b1, 1'b1, 16'h1003);
    check_bp(1'b0);
  endtask

  task automatic test_breakpoint;
    cur_tag = "bp";
    BP_EN   = 1'b1;
    BP_ADDR = 16'hF00D;
    press(1'b1, 1'b0, 8'd5, mk(1'b0, 1'b0, 1'b1, 8'd0), mk(1'b0, 1'b1, 1'b0, 8'd5));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 8'd4));
    tick(1'b1, 1'b1, 16'h0200);
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 8'd4));
    tick(1'b0, 1'b1, 16'hF00D);
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 8'd4));
    tick(1'b0, 1'b1, 16'h0201);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 8'd4));
    tick(1'b1, 1'b1, 16'hF00D);
    check_bp(1'b1);
    BP_EN = 1'b0;
  endtask

  task automatic test_stall;
    cur_tag = "stall";
    press(1'b1, 1'b0, 8'd2, mk(1'b0, 1'b0, 1'b1, 8'd4), mk(1'b0, 1'b1, 1'b0, 8'd2));
    check_bp(1'b0);
    repeat (3) begin
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 8'd2));
      tick(1'b1, 1'b0, 16'h0300);
    end
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 8'd1));
    tick(1'b1, 1'b1, 16'h0300);
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 8'd1));
    tick(1'b0, 1'b1, 16'h0301);
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 8'd0));
    tick(1'b1, 1'b1, 16'h0302);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 8'd0));
    tick(1'b1, 1'b0, 16'h0303);
  endtask

  task automatic test_abort;
    cur_tag = "abort_done";
    press(1'b0, 1'b1, 8'd0, mk(1'b0, 1'b0, 1'b1, 8'd0), mk(1'b0, 1'b0, 1'b0, 8'd0));
    cur_tag = "start_and_abort";
    press(1'b1, 1'b1, 8'd4, mk(1'b0, 1'b0, 1'b0, 8'd0), mk(1'b0, 1'b0, 1'b0, 8'd0));
    cur_tag = "abort_run";
    press(1'b1, 1'b0, 8'd9, mk(1'b0, 1'b0, 1'b0, 8'd0), mk(1'b0, 1'b1, 1'b0, 8'd9));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 8'd8));
    tick(1'b1, 1'b1, 16'h0600);
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 8'd7));
    tick(1'b1, 1'b1, 16'h0601);
    press(1'b0, 1'b1, 8'd9, mk(1'b1, 1'b1, 1'b0, 8'd7), mk(1'b1, 1'b0, 1'b0, 8'd0));
  endtask

  task automatic test_zero_steps;
    cur_tag = "zero";
    press(1'b1, 1'b0, 8'd0, mk(1'b0, 1'b0, 1'b0, 8'd0), mk(1'b0, 1'b0, 1'b1, 8'd0));
    repeat (2) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 8'd0));
      tick(1'b1, 1'b1, 16'h0400);
    end
    check_bp(1'b0);
    cur_tag = "one_step";
    press(1'b1, 1'b0, 8'd1, mk(1'b0, 1'b0, 1'b1, 8'd0), mk(1'b0, 1'b1, 1'b0, 8'd1));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 8'd0));
    tick(1'b1, 1'b1, 16'h0500);
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 8'd0));
    tick(1'b0, 1'b1, 16'h0501);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 8'd0));
    tick(1'b1, 1'b1, 16'h0502);
  endtask

  task automatic test_reset_mid_run;
    cur_tag = "rst_run";
    press(1'b1, 1'b0, 8'd10, mk(1'b0, 1'b0, 1'b1, 8'd0), mk(1'b0, 1'b1, 1'b0, 8'd10));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 8'd9));
    tick(1'b1, 1'b1, 16'h0700);
    RESET = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'd0));
    tick(1'b0, 1'b1, 16'h0000);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0));
    tick(1'b1, 1'b1, 16'h0701);
    RESET = 1'b0;
    check_bp(1'b0);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0));
    tick(1'b1, 1'b1, 16'h0702);
  endtask

  initial begin
    test_reset();
    test_count();
    test_breakpoint();
    test_stall();
    test_abort();
    test_zero_steps();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
